divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The module SHALL have ports: clk  input  1  system clock, rising-edge active.
REQ-002 The module SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 The module SHALL have ports: start  input  1  request a division; sampled only in IDLE.
REQ-004 The module SHALL have ports: sgn  input  1  1 = signed two's-complement operands, 0 = unsigned.
REQ-005 The module SHALL have ports: x  input  32  dividend.
REQ-006 The module SHALL have ports: y  input  32  divisor.
REQ-007 The module SHALL have ports: quot  output  32  quotient, registered.
REQ-008 The module SHALL have ports: rem  output  32  remainder, registered.
REQ-009 The module SHALL have ports: busy  output  1  high while an operation is in progress.
REQ-010 The module SHALL have ports: done  output  1  one-cycle pulse; quot/rem valid.
REQ-011 The module SHALL have ports: div_zero  output  1  registered with done; last operation had y == 0.

Function
REQ-012 The state machine SHALL have states IDLE, CALC and FIN.
REQ-013 IDLE SHALL move to CALC on start == 1, and SHALL latch sgn, |x|, |y| and the result signs on that edge (edge 0).
- Absolute values apply only when sgn == 1.
- Quotient sign = sign(x) XOR sign(y); remainder sign = sign(x).
REQ-014 CALC SHALL perform one restoring shift/subtract iteration per clock, 32 iterations in total, on edges 1..32.
- Iteration counter 6 bits.
- Partial remainder 33 bits, so that the unsigned subtract never loses carry.
REQ-015 FIN SHALL run at edge 33 and SHALL:
- apply sign correction;
- register quot, rem and div_zero;
- pulse done for exactly one cycle;
- return to IDLE.
REQ-016 Normal latency SHALL be 33 clocks from the start-sampling edge to the edge that raises done.
REQ-017 busy SHALL rise on edge 0 and fall on the same edge that raises done.
REQ-018 start asserted while busy == 1 SHALL be ignored; it SHALL NOT queue.
REQ-019 start asserted in the cycle that done is high SHALL be accepted, since the state is IDLE; back-to-back throughput SHALL be 34 clocks per operation.
REQ-020 Quotient SHALL truncate toward zero; remainder SHALL carry the sign of the dividend; x == quot*y + rem SHALL hold for all non-exception cases.
REQ-021 Divide by zero (y == 0, either mode) SHALL skip CALC and go IDLE -> FIN, with done at edge 1 and the following results:
- quot = 0xFFFFFFFF;
- rem = x;
- div_zero = 1.
REQ-022 Signed overflow (sgn == 1, x = 0x80000000, y = 0xFFFFFFFF) SHALL produce the following at normal latency:
- quot = 0x80000000;
- rem = 0;
- div_zero = 0.
REQ-023 quot, rem and div_zero SHALL hold their values until the next FIN or reset.
REQ-024 x, y and sgn MAY change after edge 0 without affecting the operation in progress.
REQ-025 Unsigned mode SHALL treat the full 32 bits as magnitude (e.g. 0xFFFFFFFF / 2 = 0x7FFFFFFF).

Reset
REQ-026 While rst_n == 0, without waiting for clk, the block SHALL enter state IDLE, and the following SHALL be 0:
- quot, rem;
- busy, done, div_zero;
- the iteration counter and internal registers.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-028 The first start after rst_n rises SHALL be accepted on the first rising clk edge.

Verification
REQ-029 Unsigned basic: sgn=0, x=100, y=7, start 1 cycle -> done exactly 33 clocks later; quot=14, rem=2, div_zero=0; busy high for 33 cycles.
REQ-030 Signed mixed signs: sgn=1, x=-7 (0xFFFFFFF9), y=2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
REQ-031 Exceptions:
- sgn=1, x=0x80000000, y=0xFFFFFFFF -> quot=0x80000000, rem=0.
- sgn=0, x=0x1234, y=0 -> done 1 clock after start; quot=0xFFFFFFFF, rem=0x1234, div_zero=1.
REQ-032 Handshake:
- start re-pulsed at cycle 10 of an operation -> ignored; exactly one done pulse.
- start held high through done -> second operation begins on the done cycle, with the next done 34 clocks after the first.
REQ-033 Reset mid-op: rst_n low at cycle 15 of CALC -> busy, done, quot, rem all 0 immediately; no done pulse; new operation after release completes correctly.
REQ-034 Random: 10^5 random (x, y, sgn) with y != 0 checked against a reference model of REQ-020 at 33-clock latency.

Source files
------------

// File: rtl/divider.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// divider -- 32-bit sequential restoring divider, signed or unsigned.
//
// One quotient bit is resolved per clock. An accepted request takes 33 clocks
// from the start-sampling edge to the edge that raises done. Division by zero
// skips the iterations and finishes after a single clock.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous reset, active low
//   start    in   1  request a division (sampled only while idle)
//   sgn      in   1  1 = two's-complement operands, 0 = unsigned
//   x        in  32  dividend
//   y        in  32  divisor
//   quot     out 32  quotient (registered, held until the next result)
//   rem      out 32  remainder (registered, sign follows the dividend)
//   busy     out  1  operation in progress
//   done     out  1  one-cycle pulse, quot/rem/div_zero valid
//   div_zero out  1  last operation had a zero divisor
// -----------------------------------------------------------------------------
module divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] prem_q, prem_d;   // partial remainder
  logic [31:0] dvd_q, dvd_d;     // dividend magnitude, shifts into quotient
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        dz_q, dz_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        done_q, done_d;
  logic        divz_q, divz_d;

  // Two's-complement negate when neg is set; used both for taking magnitudes
  // and for restoring signs on the result.
  function automatic logic [31:0] apply_sign(input logic [31:0] mag, input logic neg);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

  logic        x_neg, y_neg;
  logic [33:0] shl;
  logic        ge;
  logic [32:0] sub;
  logic [31:0] r_mag;

  assign x_neg = sgn & x[31];
  assign y_neg = sgn & y[31];

  // Restoring step: shift the next dividend bit in, subtract if it fits.
  // When ge holds the true difference is below the divisor, so 33 bits suffice.
  assign shl   = {prem_q, dvd_q[31]};
  assign ge    = (shl >= {2'b00, dvs_q});
  assign sub   = shl[32:0] - {1'b0, dvs_q};

  // On a zero divisor the remainder is the original dividend, which is the
  // stored magnitude with the dividend sign put back.
  assign r_mag = dz_q ? dvd_q : prem_q[31:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    divz_d  = divz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = apply_sign(x, x_neg);
          dvs_d   = apply_sign(y, y_neg);
          qneg_d  = x_neg ^ y_neg;
          rneg_d  = x_neg;
          dz_d    = (y == 32'd0);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = (y == 32'd0) ? FIN : CALC;
        end
      end
      CALC: begin
        prem_d = ge ? sub : shl[32:0];
        dvd_d  = {dvd_q[30:0], ge};
        cnt_d  = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = FIN;
      end
      FIN: begin
        quot_d  = dz_q ? 32'hFFFF_FFFF : apply_sign(dvd_q, qneg_q);
        rem_d   = apply_sign(r_mag, rneg_q);
        divz_d  = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      divz_q  <= divz_d;
    end
  end

  assign quot     = quot_q;
  assign rem      = rem_q;
  assign done     = done_q;
  assign div_zero = divz_q;
  assign busy     = (state_q != IDLE);

endmodule
